// File: rtl/dp_fifo_ram.sv
// dp_fifo_ram: dual-port word store, addressed RAM (FIFO_MODE=0) or pointer-driven FIFO (FIFO_MODE=1).
// Define DP_FIFO_RAM_PARITY_EN to store an even-parity bit per word and report parity_err on reads.
module dp_fifo_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_MODE  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`ifdef DP_FIFO_RAM_PARITY_EN
    ,output logic                 parity_err
`endif
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef DP_FIFO_RAM_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif
    localparam bit FIFO = (FIFO_MODE != 0);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [MEM_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [ADDR_WIDTH-1:0] wa, ra;
    logic [MEM_WIDTH-1:0] wr_word, rd_word;
    logic wr_en, rd_en;

`ifdef DP_FIFO_RAM_PARITY_EN
    assign wr_word = {^data_in, data_in};
`else
    assign wr_word = data_in;
`endif

    // A read frees a slot when full, so a same-cycle write is still accepted
    always_comb begin
        wr_en   = FIFO ? write && (!full || read) : write;
        rd_en   = FIFO ? read && !empty : read;
        wa      = FIFO ? wr_ptr[ADDR_WIDTH-1:0] : wr_address;
        ra      = FIFO ? rd_ptr[ADDR_WIDTH-1:0] : rd_address;
        wr_nxt  = (FIFO && wr_en) ? wr_ptr + PTR_ONE : wr_ptr;
        rd_nxt  = (FIFO && rd_en) ? rd_ptr + PTR_ONE : rd_ptr;
        rd_word = mem[ra];
    end

    always_ff @(posedge clock) begin
        if (!reset && wr_en)
            mem[wa] <= wr_word;
    end

    // Flags are computed from the next pointers so they match the post-edge state
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            full       <= 1'b0;
            empty      <= FIFO;
            count      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
`ifdef DP_FIFO_RAM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            if (rd_en)
                data_out <= rd_word[DATA_WIDTH-1:0];
            data_valid <= rd_en;
            full       <= FIFO && (wr_nxt[ADDR_WIDTH-1:0] == rd_nxt[ADDR_WIDTH-1:0]) && (wr_nxt[ADDR_WIDTH] != rd_nxt[ADDR_WIDTH]);
            empty      <= FIFO && (wr_nxt == rd_nxt);
            count      <= FIFO ? wr_nxt - rd_nxt : '0;
            overflow   <= FIFO && write && !wr_en;
            underflow  <= FIFO && read && !rd_en;
`ifdef DP_FIFO_RAM_PARITY_EN
            parity_err <= rd_en && (^rd_word);
`endif
        end
    end
endmodule

// File: tb/tb_dp_fifo_ram.sv
// tb_dp_fifo_ram: directed scoreboard bench, one RAM-mode and one FIFO-mode instance.
module tb_dp_fifo_ram;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic r_rst, r_wr, r_rd, r_dv, r_full, r_empty, r_ovf, r_unf;
    logic [11:0] r_wa, r_ra;
    logic [63:0] r_din, r_dout;
    logic [12:0] r_cnt;
    logic f_rst, f_wr, f_rd, f_dv, f_full, f_empty, f_ovf, f_unf;
    logic [2:0] f_wa, f_ra;
    logic [7:0] f_din, f_dout;
    logic [3:0] f_cnt;
`ifdef DP_FIFO_RAM_PARITY_EN
    logic r_perr, f_perr;
`endif

    dp_fifo_ram #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .FIFO_MODE(0)) dut_ram (
        .clock(clock), .reset(r_rst), .write(r_wr), .wr_address(r_wa), .data_in(r_din),
        .read(r_rd), .rd_address(r_ra), .data_out(r_dout), .data_valid(r_dv),
        .full(r_full), .empty(r_empty), .count(r_cnt), .overflow(r_ovf), .underflow(r_unf)
`ifdef DP_FIFO_RAM_PARITY_EN
        , .parity_err(r_perr)
`endif
    );

    dp_fifo_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FIFO_MODE(1)) dut_ff (
        .clock(clock), .reset(f_rst), .write(f_wr), .wr_address(f_wa), .data_in(f_din),
        .read(f_rd), .rd_address(f_ra), .data_out(f_dout), .data_valid(f_dv),
        .full(f_full), .empty(f_empty), .count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
`ifdef DP_FIFO_RAM_PARITY_EN
        , .parity_err(f_perr)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] ram_m [int];
    logic [63:0] ram_q [$];
    logic [63:0] ram_last = '0;
    logic [7:0] ff_m [$];
    logic [7:0] ff_q [$];
    logic [7:0] ff_last = '0;
    logic exp_perr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ram_step(input logic w, input logic [11:0] wa, input logic [63:0] d, input logic r, input logic [11:0] ra);
        r_wr = w; r_wa = wa; r_din = d; r_rd = r; r_ra = ra;
        if (r) ram_q.push_back(ram_m.exists(int'(ra)) ? ram_m[int'(ra)] : 64'hx);
        if (w) ram_m[int'(wa)] = d;
        @(posedge clock); #1;
        chk("ram_dv", 64'(r_dv), 64'(r));
        if (r_dv && ram_q.size() > 0) ram_last = ram_q.pop_front();
        chk("ram_dout", r_dout, ram_last);
        chk("ram_status", 64'({r_full, r_empty, r_ovf, r_unf, r_cnt}), 64'd0);
`ifdef DP_FIFO_RAM_PARITY_EN
        chk("ram_perr", 64'(r_perr), 64'd0);
`endif
        r_wr = 1'b0; r_rd = 1'b0;
    endtask

    task automatic ff_step(input logic w, input logic [7:0] d, input logic r);
        logic fl, wacc, racc;
        fl   = (ff_m.size() == 8);
        racc = r && (ff_m.size() != 0);
        wacc = w && (!fl || r);
        f_wr = w; f_din = d; f_rd = r; f_wa = 3'($urandom); f_ra = 3'($urandom);
        if (racc) ff_q.push_back(ff_m.pop_front());
        if (wacc) ff_m.push_back(d);
        @(posedge clock); #1;
        chk("ff_dv", 64'(f_dv), 64'(racc));
        if (f_dv && ff_q.size() > 0) ff_last = ff_q.pop_front();
        chk("ff_dout", 64'(f_dout), 64'(ff_last));
        chk("ff_ovf", 64'(f_ovf), 64'(w && !wacc));
        chk("ff_unf", 64'(f_unf), 64'(r && !racc));
        chk("ff_cnt", 64'(f_cnt), 64'(ff_m.size()));
        chk("ff_full", 64'(f_full), 64'(ff_m.size() == 8));
        chk("ff_empty", 64'(f_empty), 64'(ff_m.size() == 0));
`ifdef DP_FIFO_RAM_PARITY_EN
        chk("ff_perr", 64'(f_perr), 64'(racc && exp_perr));
`endif
        f_wr = 1'b0; f_rd = 1'b0;
    endtask

    initial begin
        r_rst = 1'b1; r_wr = 1'b0; r_rd = 1'b0; r_wa = '0; r_ra = '0; r_din = '0;
        f_rst = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_wa = '0; f_ra = '0; f_din = '0;
        @(posedge clock); #1;
        chk("rst_ram_dout", r_dout, 64'd0);
        chk("rst_ram_dv", 64'(r_dv), 64'd0);
        chk("rst_ram_status", 64'({r_full, r_empty, r_ovf, r_unf, r_cnt}), 64'd0);
        chk("rst_ff_empty", 64'(f_empty), 64'd1);
        chk("rst_ff_status", 64'({f_full, f_ovf, f_unf, f_dv, f_cnt}), 64'd0);
        chk("rst_ff_dout", 64'(f_dout), 64'd0);
        r_rst = 1'b0; f_rst = 1'b0;

        // RAM: basic write/read, idle hold, address boundaries
        ram_step(1, 12'hABC, 64'hDEAD_BEEF_0123_4567, 0, 12'h0);
        ram_step(0, 12'h0, 64'h0, 1, 12'hABC);
        ram_step(0, 12'h0, 64'h0, 0, 12'h0);
        ram_step(1, 12'h000, 64'h0F0F_0F0F_0F0F_0F0F, 0, 12'h0);
        ram_step(1, 12'hFFF, 64'hFFFF_0000_FFFF_0000, 1, 12'hABC);
        ram_step(0, 12'h0, 64'h0, 1, 12'hFFF);
        ram_step(0, 12'h0, 64'h0, 1, 12'h000);
        // RAM: read-first collision
        ram_step(1, 12'd5, 64'h1, 0, 12'h0);
        ram_step(1, 12'd5, 64'h2, 1, 12'd5);
        ram_step(0, 12'h0, 64'h0, 1, 12'd5);

        // FIFO: fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) ff_step(1, 8'(i), 0);
        ff_step(1, 8'd9, 0);
        for (int i = 0; i < 8; i++) ff_step(0, 8'h0, 1);
        // FIFO: full with simultaneous read+write, drain across pointer wrap
        for (int i = 1; i <= 8; i++) ff_step(1, 8'(i), 0);
        ff_step(1, 8'd9, 1);
        for (int i = 0; i < 8; i++) ff_step(0, 8'h0, 1);
        // FIFO: underflow alone and with write, no fall-through
        ff_step(0, 8'h0, 1);
        ff_step(1, 8'hAA, 1);
        ff_step(0, 8'h0, 1);
        ff_step(1, 8'h33, 1);
        ff_step(1, 8'h44, 1);
        ff_step(0, 8'h0, 1);

        // FIFO: reset mid-operation with read asserted
        for (int i = 0; i < 4; i++) ff_step(1, 8'(8'h10 + i), 0);
        f_rst = 1'b1; f_rd = 1'b1;
        @(posedge clock); #1;
        f_rst = 1'b0; f_rd = 1'b0;
        ff_m.delete(); ff_q.delete(); ff_last = '0;
        chk("rstmid_dv", 64'(f_dv), 64'd0);
        chk("rstmid_empty", 64'(f_empty), 64'd1);
        chk("rstmid_cnt", 64'(f_cnt), 64'd0);
        chk("rstmid_dout", 64'(f_dout), 64'd0);
        ff_step(1, 8'h77, 0);
        ff_step(0, 8'h0, 1);

`ifdef DP_FIFO_RAM_PARITY_EN
        // Corrupt one stored bit: read at index 1 after the 8'h77 round trip
        ff_step(1, 8'h5A, 0);
        dut_ff.mem[1][0] = ~dut_ff.mem[1][0];
        ff_m[0] = ff_m[0] ^ 8'h01;
        exp_perr = 1'b1;
        ff_step(0, 8'h0, 1);
        exp_perr = 1'b0;
        ff_step(0, 8'h0, 0);
`endif

        chk("ram_sb_drained", 64'(ram_q.size()), 64'd0);
        chk("ff_sb_drained", 64'(ff_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
